// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder.
// One single-digit BCD adder is time-shared across all DIGITS digits. The carry
// ripples from digit 0 upward, one digit per cycle. The result is held until the
// consumer takes it.

// Single-digit BCD adder: x + y + cin, decimal-corrected.
module bcd_digit_adder (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_raw;

  // Binary add, then add 6 when the result is past 9 to skip the six unused codes
  always_comb begin
    w_raw  = {1'b0, i_x} + {1'b0, i_y} + {4'b0000, i_cin};
    o_cout = 1'b0;
    o_sum  = w_raw[3:0];
    if (w_raw > 5'd9) begin
      o_cout = 1'b1;
      o_sum  = w_raw[3:0] + 4'd6;
    end
  end

endmodule

module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_a,
  input  logic [4*DIGITS-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_err,
  output logic                  busy
);

  localparam int unsigned W    = 4 * DIGITS;
  // One spare bit so the index can never wrap before the last digit is reached
  localparam int unsigned IdxW = $clog2(DIGITS) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_err;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_out_valid;

  logic [3:0]      w_x;
  logic [3:0]      w_y;
  logic [3:0]      w_d_sum;
  logic            w_d_cout;
  logic [W-1:0]    w_sum_next;
  logic            w_in_err;

  // Select the operand digits addressed by the current index
  always_comb begin
    w_x = 4'h0;
    w_y = 4'h0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IdxW'(i)) begin
        w_x = r_a[4*i +: 4];
        w_y = r_b[4*i +: 4];
      end
    end
  end

  bcd_digit_adder u_digit (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_cin  (r_carry),
    .o_sum  (w_d_sum),
    .o_cout (w_d_cout)
  );

  // Merge the freshly computed digit into the result word at the current index
  always_comb begin
    w_sum_next = r_sum;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IdxW'(i)) begin
        w_sum_next[4*i +: 4] = w_d_sum;
      end
    end
  end

  // Flag any non-decimal nibble in the operands being offered
  always_comb begin
    w_in_err = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (in_a[4*i +: 4] > 4'd9 || in_b[4*i +: 4] > 4'd9) begin
        w_in_err = 1'b1;
      end
    end
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            // Carry-in seeds the carry register so digit 0 sees it directly
            r_carry    <= in_cin;
            r_idx      <= '0;
            r_sum      <= '0;
            r_err      <= w_in_err;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StAdd;
          end
        end
        StAdd: begin
          r_sum   <= w_sum_next;
          r_carry <= w_d_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LastIdx) begin
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;
  assign out_err   = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: directed and random operand sets, scoreboard of
// expected results computed with decimal integer arithmetic.
module tb_bcd_serial_adder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    longint       acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_err;
  logic         busy;

  int     tests;
  int     fails;
  longint cyc;
  exp_t   exp_q[$];
  bit     rdy_random;
  logic   rdy_force;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Decimal reference: operands as integers, sum split back into digits
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t   e;
    longint va, vb, total, lim, rem;
    int     na, nb;
    va = 0; vb = 0; lim = 1;
    e.err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      na = int'(a[4*i +: 4]);
      nb = int'(b[4*i +: 4]);
      if (na > 9 || nb > 9) e.err = 1'b1;
      va = va * 10 + na;
      vb = vb * 10 + nb;
      lim = lim * 10;
    end
    total  = va + vb + longint'(cin);
    e.cout = (total >= lim);
    rem    = total % lim;
    e.sum  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      e.sum[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (allow_bad && $urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // Offer an operand set, hold it until accepted, then record the expected result
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready && rst_n) break;
      n++;
      if (n > 200) begin
        fail_now("accept_timeout");
        in_valid = 1'b0;
        return;
      end
    end
    e = model(a, b, cin);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        fail_now("drain_timeout");
        exp_q.delete();
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_sum"}, 64'(out_sum), 64'd0);
    chk({tag, "_out_cout"}, 64'(out_cout), 64'd0);
    chk({tag, "_out_err"}, 64'(out_err), 64'd0);
  endtask

  // Monitor: latency, hold stability, result compare on each output handshake
  initial begin
    exp_t         e;
    bit           prev_valid;
    bit           pend_idle;
    int           wait_cyc;
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_err;
    prev_valid = 0; pend_idle = 0; wait_cyc = 0;
    h_sum = '0; h_cout = 0; h_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        pend_idle  = 0;
        wait_cyc   = 0;
      end else begin
        if (pend_idle) begin
          chk("after_hs_out_valid", 64'(out_valid), 64'd0);
          chk("after_hs_in_ready", 64'(in_ready), 64'd1);
          pend_idle = 0;
        end
        if (out_valid) begin
          chk("done_in_ready_low", 64'(in_ready), 64'd0);
          chk("done_busy_high", 64'(busy), 64'd1);
        end
        if (out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_out_valid");
          end else begin
            chk("latency", 64'(cyc - exp_q[0].acc), 64'(DIGITS));
            h_sum = out_sum; h_cout = out_cout; h_err = out_err;
          end
        end else if (out_valid) begin
          chk("hold_sum", 64'(out_sum), 64'(h_sum));
          chk("hold_cout", 64'(out_cout), 64'(h_cout));
          chk("hold_err", 64'(out_err), 64'(h_err));
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_err", 64'(out_err), 64'(e.err));
          if (!e.err) begin
            chk("out_sum", 64'(out_sum), 64'(e.sum));
            chk("out_cout", 64'(out_cout), 64'(e.cout));
          end
          pend_idle = 1;
        end
        if (exp_q.size() != 0 && !out_valid) wait_cyc++;
        else wait_cyc = 0;
        if (wait_cyc > 100) begin
          fail_now("out_valid_timeout");
          exp_q.delete();
          wait_cyc = 0;
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    int n;
    tests = 0; fails = 0;
    rdy_random = 0; rdy_force = 1'b1;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic sums and full carry propagation
    send(16'h1234, 16'h5678, 1'b0);
    send(16'h9999, 16'h0000, 1'b1);
    send(16'h9999, 16'h9999, 1'b1);
    drain();

    // Consumer stalls in DONE while a second operand set is offered
    rdy_force = 1'b0;
    fork
      begin
        send(16'h0457, 16'h0388, 1'b0);
        send(16'h8001, 16'h2999, 1'b1);
      end
      begin
        n = 0;
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (!out_valid) fail_now("stall_wait");
        repeat (10) @(posedge clk);
        #1;
        rdy_force = 1'b1;
      end
    join
    drain();

    // Reset during the second ADD cycle abandons the operation
    send(16'h4321, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    send(16'h0001, 16'h0001, 1'b0);
    drain();

    // Non-decimal nibble flagged, then a clean operation clears the flag
    send(16'h00A0, 16'h0001, 1'b0);
    send(16'h0250, 16'h0750, 1'b0);
    drain();

    // Random operands with random consumer backpressure
    rdy_random = 1;
    for (int k = 0; k < 40; k++) begin
      send(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 Parameter: DIGITS, 4, number of packed-BCD digits per operand (1..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: in_a  input  4*DIGITS  packed-BCD operand A, digit 0 in bits [3:0].
REQ-007 Port: in_b  input  4*DIGITS  packed-BCD operand B, same packing.
REQ-008 Port: in_cin  input  1  decimal carry-in to digit 0.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: out_sum  output  4*DIGITS  packed-BCD sum.
REQ-012 Port: out_cout  output  1  decimal carry-out of the most significant digit.
REQ-013 Port: out_err  output  1  at least one operand nibble was >9 at acceptance.
REQ-014 Port: busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL contain exactly one single-digit BCD adder instance (the team's existing 4-bit BCD digit adder: x, y, cin -> sum, cout) and time-share it across all digits.
REQ-016 The FSM SHALL have states IDLE, ADD, DONE; no other reachable states.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready at an edge, latch in_a, in_b, in_cin into operand registers, clear digit index to 0, clear result register, go to ADD.
REQ-018 in_ready SHALL be 0 in ADD and DONE; in_valid and operand inputs SHALL be ignored there.
REQ-019 ADD: each cycle the digit adder receives operand digits [idx] and the carry register (in_cin for idx=0); at the edge, the sum nibble is written to result nibble idx, the carry register takes the adder's cout, and idx increments.
REQ-020 ADD SHALL last exactly DIGITS cycles; at the edge writing idx=DIGITS-1, go to DONE; out_valid is first high DIGITS cycles after the acceptance edge.
REQ-021 DONE: out_valid=1; out_sum, out_cout, out_err SHALL hold stable until out_valid&&out_ready at an edge, then go to IDLE.
REQ-022 out_valid SHALL be 0 in IDLE and ADD; in_ready returns to 1 the cycle after the output handshake (no same-cycle accept in DONE).
REQ-023 out_cout SHALL equal the final carry register value; the carry chain SHALL ripple digit 0 to digit DIGITS-1 only.
REQ-024 out_err SHALL be computed from the latched operands at acceptance; the sum is still produced, its value unspecified when out_err=1.
REQ-025 idx SHALL be ceil(log2(DIGITS))+1 bits wide at minimum; no wrap may occur before the transition to DONE; DIGITS=1 SHALL give one ADD cycle.
REQ-026 out_sum SHALL be driven from the result register only (no combinational path from in_a/in_b).

Reset
REQ-027 While rst_n=0 at an edge: state IDLE, idx 0, carry 0, operand and result registers 0, out_err 0.
REQ-028 Outputs after reset: in_ready=1, busy=0, out_valid=0, out_sum=0, out_cout=0, out_err=0.
REQ-029 Reset in ADD or DONE SHALL abandon the operation; no partial result is ever presented.

Verification (DIGITS=4)
REQ-030 in_a=0x1234, in_b=0x5678, in_cin=0, out_ready=1 -> out_sum=0x6912, out_cout=0, out_err=0, out_valid rises 4 cycles after accept.
REQ-031 in_a=0x9999, in_b=0x0000, in_cin=1 -> out_sum=0x0000, out_cout=1.
REQ-032 in_a=0x9999, in_b=0x9999, in_cin=1 -> out_sum=0x9999, out_cout=1.
REQ-033 out_ready held 0 for 10 cycles in DONE, in_valid=1 with new operands throughout -> outputs unchanged, in_ready=0, second operand set accepted only the cycle after the out handshake.
REQ-034 rst_n=0 on the 2nd ADD cycle -> next cycle in_ready=1, busy=0, out_valid=0, out_sum=0; a following 0x0001+0x0001 yields 0x0002.
REQ-035 in_a=0x00A0, in_b=0x0001 -> out_err=1 with out_valid; next clean operation gives out_err=0.
